// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: FSM encodings, the nop word
// and a saturating increment used by the optional FETCH_PERF_EN counters.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'd0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: stall/redirect/halt control in, imem port and FD-latch
// offer out. The slave modport is the fetch stage itself.
interface fetch_stage_if #(
  parameter int IMEM_AW = 12
);
  logic               pc_enable;
  logic               redirect_valid;
  logic [31:0]        redirect_target;
  logic               halt_req;
  logic               resume;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_q;
  logic [31:0]        curr_pc_instruction;
  logic [31:0]        fetch_pc;
  logic               flush_FD;
  logic               flush_DX;

  modport master (
    output pc_enable, redirect_valid, redirect_target, halt_req, resume, imem_q,
    input  imem_addr, curr_pc_instruction, fetch_pc, flush_FD, flush_DX
  );

  modport slave (
    input  pc_enable, redirect_valid, redirect_target, halt_req, resume, imem_q,
    output imem_addr, curr_pc_instruction, fetch_pc, flush_FD, flush_DX
  );
endinterface

// File: rtl/fetch_stage_pc_next_sel.sv
// Next-PC selection: redirect beats stall; the PC only advances in RUN.
module pc_next_sel
  import fetch_stage_pkg::*;
(
  input  logic [31:0]  i_pc,
  input  fetch_state_e i_state,
  input  logic         i_pc_enable,
  input  logic         i_redirect_valid,
  input  logic [31:0]  i_redirect_target,
  output logic [31:0]  o_next_pc
);

  always_comb begin
    o_next_pc = i_pc;
    if (i_redirect_valid)
      o_next_pc = i_redirect_target;
    else if (i_state == ST_RUN && i_pc_enable)
      o_next_pc = i_pc + 32'd1;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with FILL/RUN/HALT sequencing over a 1-cycle imem.
// Optional build macro FETCH_PERF_EN adds saturating stall/redirect counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          IMEM_AW  = 12
) (
  input  logic        clock,
  input  logic        reset,
  fetch_stage_if.slave bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] redirect_count
`endif
);

  logic [31:0]  r_pc;
  fetch_state_e r_state;
  logic [31:0]  w_next_pc;

  pc_next_sel u_pc_next_sel (
    .i_pc              (r_pc),
    .i_state           (r_state),
    .i_pc_enable       (bus.pc_enable),
    .i_redirect_valid  (bus.redirect_valid),
    .i_redirect_target (bus.redirect_target),
    .o_next_pc         (w_next_pc)
  );

  // imem is addressed with next_pc so its registered output lines up with r_pc
  assign bus.imem_addr           = w_next_pc[IMEM_AW-1:0];
  assign bus.curr_pc_instruction = (r_state == ST_RUN) ? bus.imem_q : NOP_INSTR;
  assign bus.fetch_pc            = r_pc;
  assign bus.flush_FD            = bus.redirect_valid;
  assign bus.flush_DX            = bus.redirect_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_state <= ST_FILL;
    end else begin
      r_pc <= w_next_pc;
      case (r_state)
        ST_FILL: r_state <= bus.halt_req ? ST_HALT : ST_RUN;
        ST_RUN:  if (bus.halt_req) r_state <= ST_HALT;
        ST_HALT: if (bus.resume && !bus.halt_req) r_state <= ST_RUN;
        default: r_state <= ST_FILL;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count    <= 32'd0;
      redirect_count <= 32'd0;
    end else begin
      if (r_state == ST_RUN && !bus.pc_enable && !bus.redirect_valid)
        stall_count <= sat_inc(stall_count);
      if (bus.redirect_valid)
        redirect_count <= sat_inc(redirect_count);
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0, PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_AW, default 12, instruction-memory address width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pc_enable  input  1  from stall logic; 0 = hold PC (load-use stall).
REQ-006 SHALL have port redirect_valid  input  1  taken branch/jump resolved in X stage.
REQ-007 SHALL have port redirect_target  input  32  PC of the redirect destination.
REQ-008 SHALL have port halt_req  input  1  stop fetching.
REQ-009 SHALL have port resume  input  1  leave halt.
REQ-010 SHALL have port imem_addr  output  IMEM_AW  address to synchronous imem (1-cycle read latency).
REQ-011 SHALL have port imem_q  input  32  imem data for the address presented on the previous edge.
REQ-012 SHALL have port curr_pc_instruction  output  32  instruction offered to the FD latch.
REQ-013 SHALL have port fetch_pc  output  32  PC of curr_pc_instruction.
REQ-014 SHALL have ports flush_FD and flush_DX  output  1 each  squash wrong-path FD/DX contents.

Function
REQ-015 SHALL hold a 32-bit PC register and a 2-bit state register with states FILL, RUN, HALT.
REQ-016 SHALL compute next_pc with priority: redirect_valid -> redirect_target; else state RUN and pc_enable=1 -> pc+1 (mod 2^32); else pc.
REQ-017 SHALL drive imem_addr = next_pc[IMEM_AW-1:0] combinationally, so imem_q in the following cycle corresponds to the PC register.
REQ-018 SHALL drive curr_pc_instruction = imem_q only in RUN, else 32'd0 (nop).
REQ-019 SHALL drive fetch_pc = PC register in every state.
REQ-020 SHALL transition FILL -> RUN after one clock edge; FILL -> HALT if halt_req=1 on that edge.
REQ-021 SHALL transition RUN -> HALT when halt_req=1; HALT -> RUN when resume=1 and halt_req=0; halt_req wins over resume.
REQ-022 SHALL freeze the PC in HALT except when redirect_valid=1, which loads redirect_target without leaving HALT.
REQ-023 SHALL assert flush_FD = flush_DX = redirect_valid combinationally in all states, also when pc_enable=0.
REQ-024 SHALL ignore pc_enable=0 when redirect_valid=1 (redirect overrides stall).
REQ-025 SHALL wrap PC from 32'hFFFFFFFF to 0 without error indication; imem_addr uses only the low IMEM_AW bits.

Reset
REQ-026 SHALL on reset set PC=RESET_PC, state=FILL, curr_pc_instruction=0, fetch_pc=RESET_PC, flush_FD=flush_DX=redirect_valid, and all counters to 0, asynchronously and mid-operation.
REQ-027 SHALL NOT issue a non-nop instruction in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL, with FETCH_PERF_EN defined, add 32-bit outputs stall_count (increments each RUN cycle with pc_enable=0 and redirect_valid=0) and redirect_count (increments each cycle with redirect_valid=1), both saturating at 32'hFFFFFFFF.
REQ-029 SHALL, without FETCH_PERF_EN, have neither these ports nor these counters, with all other behaviour identical.

Structure
REQ-030 SHALL take the state encodings (FILL=2'd0, RUN=2'd1, HALT=2'd2) and the 32'd0 nop constant from the shared pipeline package.
REQ-031 SHALL implement next-PC selection in one sub-module, pc_next_sel; all other logic stays in fetch_stage.

Verification
REQ-032 SHALL test: reset with RESET_PC=0x10, release -> cycle 1 output nop, fetch_pc=0x10; cycle 2 imem[0x10] with fetch_pc=0x10; cycle 3 imem[0x11] with fetch_pc=0x11.
REQ-033 SHALL test: pc_enable=0 for 2 cycles at PC=0x20 -> fetch_pc stays 0x20, instruction imem[0x20] repeats, stall_count +2.
REQ-034 SHALL test: redirect_valid=1, target=0x40, pc_enable=0 in the same cycle -> flush_FD=flush_DX=1 that cycle; next cycle fetch_pc=0x40, instruction imem[0x40]; redirect_count +1.
REQ-035 SHALL test: halt_req at PC=0x08 -> nop outputs, PC frozen; resume -> imem[0x08] next cycle; halt_req and resume together -> stays HALT.
REQ-036 SHALL test: PC=0xFFFFFFFF in RUN -> next fetch_pc=0, imem_addr=0; reset asserted mid-stall -> PC=RESET_PC and state FILL immediately.
